// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue
//   Fetch stage for the core. It owns the fetch PC and issues in-order word
//   requests to a variable-latency instruction memory. Returned words are
//   tagged with their PC and held in a DEPTH-entry FIFO that feeds decode.
//   A redirect flushes the FIFO, restarts fetch at the new PC, and discards
//   every response that is still outstanding at that moment.
//
// Ports
//   clk, rst                 clock and synchronous active-high reset
//   imem_req_valid/ready     request handshake toward instruction memory
//   imem_req_addr            word-aligned request address (current fetch PC)
//   imem_rsp_valid/data      in-order response words, no back-pressure
//   out_valid/ready          head-of-queue handshake toward decode
//   out_instr, out_pc        head instruction and its PC
//   redirect_valid/pc        flush and restart fetch (low two bits ignored)
//   count                    number of queued entries
module instr_fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req_valid,
  input  logic                       imem_req_ready,
  output logic [XLEN-1:0]            imem_req_addr,
  input  logic                       imem_rsp_valid,
  input  logic [XLEN-1:0]            imem_rsp_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_instr,
  output logic [XLEN-1:0]            out_pc,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [XLEN-1:0] fetch_pc_reg;
  logic [XLEN-1:0] rsp_pc_reg;
  logic [CW-1:0]   count_reg;
  logic [CW-1:0]   count_next;
  logic [CW-1:0]   inflight_reg;
  logic [CW-1:0]   inflight_next;
  logic [CW-1:0]   drop_cnt_reg;
  logic [PW-1:0]   wr_ptr_reg;
  logic [PW-1:0]   rd_ptr_reg;

  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];

  logic [CW:0]     occupancy;
  logic            req_fire;
  logic            rsp_fire;
  logic            rsp_drop;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] redirect_aligned;

  // A FIFO slot is reserved for every word in flight, so capping
  // queued + in-flight at DEPTH guarantees a push can never overflow.
  assign occupancy      = {1'b0, count_reg} + {1'b0, inflight_reg};
  assign imem_req_valid = !rst && !redirect_valid && (occupancy < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_reg;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored
  // so the counters never underflow.
  assign rsp_fire = imem_rsp_valid && (inflight_reg != '0);
  assign rsp_drop = rsp_fire && (drop_cnt_reg != '0);
  assign push     = rsp_fire && (drop_cnt_reg == '0) && !redirect_valid;

  assign out_valid = (count_reg != '0) && !redirect_valid;
  assign pop       = out_valid && out_ready;
  assign out_instr = instr_mem[rd_ptr_reg];
  assign out_pc    = pc_mem[rd_ptr_reg];
  assign count     = count_reg;

  assign redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};

  always_comb begin
    inflight_next = inflight_reg;
    if (req_fire && !rsp_fire) begin
      inflight_next = inflight_reg + CW'(1);
    end else if (!req_fire && rsp_fire) begin
      inflight_next = inflight_reg - CW'(1);
    end
  end

  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + CW'(1);
    end else if (pop && !push) begin
      count_next = count_reg - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_reg <= RESET_PC;
      rsp_pc_reg   <= RESET_PC;
      count_reg    <= '0;
      inflight_reg <= '0;
      drop_cnt_reg <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
    end else begin
      inflight_reg <= inflight_next;
      if (redirect_valid) begin
        // No request issues during a redirect, so inflight_next is exactly
        // the number of words still owed by memory; all of them are stale.
        fetch_pc_reg <= redirect_aligned;
        rsp_pc_reg   <= redirect_aligned;
        count_reg    <= '0;
        wr_ptr_reg   <= '0;
        rd_ptr_reg   <= '0;
        drop_cnt_reg <= inflight_next;
      end else begin
        count_reg <= count_next;
        if (req_fire) begin
          fetch_pc_reg <= fetch_pc_reg + XLEN'(4);
        end
        if (rsp_drop) begin
          drop_cnt_reg <= drop_cnt_reg - CW'(1);
        end
        if (push) begin
          rsp_pc_reg <= rsp_pc_reg + XLEN'(4);
          wr_ptr_reg <= wr_ptr_reg + PW'(1);
        end
        if (pop) begin
          rd_ptr_reg <= rd_ptr_reg + PW'(1);
        end
      end
    end
  end

  // Entry storage is cleared on reset so the head reads as zero until the
  // first word lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else if (push) begin
      instr_mem[wr_ptr_reg] <= imem_rsp_data;
      pc_mem[wr_ptr_reg]    <= rsp_pc_reg;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue. A small memory model returns
// (addr ^ KEY) for each accepted request, in order, one cycle after
// acceptance unless rsp_hold is set. Inputs change and outputs are sampled
// just after the falling edge.
module tb_instr_fetch_queue;

  localparam int          XLEN  = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] KEY   = 32'hDEAD_0000;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [2:0]  count;

  logic        rsp_hold;
  logic [31:0] pend_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .count          (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // In-order memory: a request accepted at edge N is answered at edge N+1.
  always @(posedge clk) begin
    if (rst) begin
      pend_q.delete();
      imem_rsp_valid <= 1'b0;
      imem_rsp_data  <= '0;
    end else begin
      if (imem_req_valid && imem_req_ready) pend_q.push_back(imem_req_addr);
      if (!rsp_hold && pend_q.size() > 0) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= pend_q.pop_front() ^ KEY;
      end else begin
        imem_rsp_valid <= 1'b0;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; out_ready = 1'b0; rsp_hold = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b1; out_ready = 1'b1; rsp_hold = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_instr !== 32'h0) begin n_fail++; $display("FAIL reset_out_instr: got %h expected 0", out_instr); end
    n_checks++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL reset_out_pc: got %h expected 0", out_pc); end
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
    rst = 1'b0;
    #1;
    n_checks++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL reset_release_req_valid: got %b expected 1", imem_req_valid); end
    n_checks++; if (imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL reset_release_addr: got %h expected 0", imem_req_addr); end
    $display("test_reset done");
  endtask

  // Streaming with 1-cycle memory and out_ready high: one instruction per cycle.
  task automatic test_stream();
    logic [31:0] exp_pc;
    do_reset();
    imem_req_ready = 1'b1; out_ready = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (imem_req_addr !== 32'(4 * i)) begin n_fail++; $display("FAIL stream_addr[%0d]: got %h expected %h", i, imem_req_addr, 32'(4 * i)); end
      n_checks++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL stream_req_valid[%0d]: got %b expected 1", i, imem_req_valid); end
      if (i >= 2) begin
        exp_pc = 32'(4 * (i - 2));
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_out_valid[%0d]: got %b expected 1", i, out_valid); end
        n_checks++; if (out_pc !== exp_pc) begin n_fail++; $display("FAIL stream_out_pc[%0d]: got %h expected %h", i, out_pc, exp_pc); end
        n_checks++; if (out_instr !== (exp_pc ^ KEY)) begin n_fail++; $display("FAIL stream_out_instr[%0d]: got %h expected %h", i, out_instr, exp_pc ^ KEY); end
        n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL stream_count[%0d]: got %0d expected 1", i, count); end
        $display("stream pop pc=%h instr=%h", out_pc, out_instr);
      end else begin
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_fill_out_valid[%0d]: got %b expected 0", i, out_valid); end
      end
      @(negedge clk); #1;
    end
  endtask

  // Consumer stalled: queue fills to DEPTH, requests stop, then drains in order.
  task automatic test_backpressure();
    logic [31:0] exp_pc;
    do_reset();
    imem_req_ready = 1'b1; out_ready = 1'b0;
    #1;
    repeat (5) @(negedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL bp_count[%0d]: got %0d expected 4", s, count); end
      n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_req_valid[%0d]: got %b expected 0", s, imem_req_valid); end
      n_checks++; if (imem_req_addr !== 32'h10) begin n_fail++; $display("FAIL bp_addr[%0d]: got %h expected 10", s, imem_req_addr); end
      n_checks++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL bp_head_pc[%0d]: got %h expected 0", s, out_pc); end
      @(negedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk); #1;
      exp_pc = 32'(4 * k);
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_drain_valid[%0d]: got %b expected 1", k, out_valid); end
      n_checks++; if (out_pc !== exp_pc) begin n_fail++; $display("FAIL bp_drain_pc[%0d]: got %h expected %h", k, out_pc, exp_pc); end
      n_checks++; if (out_instr !== (exp_pc ^ KEY)) begin n_fail++; $display("FAIL bp_drain_instr[%0d]: got %h expected %h", k, out_instr, exp_pc ^ KEY); end
      if (k == 1) begin
        n_checks++; if (imem_req_addr !== 32'h10 || imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL bp_resume: got valid=%b addr=%h expected valid=1 addr=10", imem_req_valid, imem_req_addr); end
      end
      $display("drain pop pc=%h instr=%h", out_pc, out_instr);
    end
  endtask

  // Memory not ready: request address and valid held, nothing issued.
  task automatic test_req_stall();
    do_reset();
    imem_req_ready = 1'b0; out_ready = 1'b1;
    #1;
    for (int s = 0; s < 3; s++) begin
      n_checks++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b expected 1", s, imem_req_valid); end
      n_checks++; if (imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL stall_addr[%0d]: got %h expected 0", s, imem_req_addr); end
      n_checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL stall_out[%0d]: got valid=%b count=%0d expected 0/0", s, out_valid, count); end
      @(negedge clk); #1;
    end
    imem_req_ready = 1'b1;
    @(negedge clk); #1;
    n_checks++; if (imem_req_addr !== 32'h4) begin n_fail++; $display("FAIL stall_release_addr: got %h expected 4", imem_req_addr); end
    @(negedge clk); #1;
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin n_fail++; $display("FAIL stall_first_out: got valid=%b pc=%h expected 1/0", out_valid, out_pc); end
  endtask

  // Redirect with two words in flight: both are discarded.
  task automatic test_redirect_inflight();
    do_reset();
    imem_req_ready = 1'b1; out_ready = 1'b1; rsp_hold = 1'b1;
    #1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (imem_req_addr !== 32'h8) begin n_fail++; $display("FAIL redir_pre_addr: got %h expected 8", imem_req_addr); end
    imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h103;
    #1;
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL redir_req_blocked: got %b expected 0", imem_req_valid); end
    @(negedge clk);
    redirect_valid = 1'b0; imem_req_ready = 1'b1; rsp_hold = 1'b0;
    #1;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL redir_count: got %0d expected 0", count); end
    n_checks++; if (imem_req_addr !== 32'h100 || imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL redir_addr: got valid=%b addr=%h expected 1/100", imem_req_valid, imem_req_addr); end
    for (int j = 4; j <= 6; j++) begin
      @(negedge clk); #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_stale_out[%0d]: got %b expected 0 (pc=%h)", j, out_valid, out_pc); end
    end
    @(negedge clk); #1;
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h100) begin n_fail++; $display("FAIL redir_first_pc: got valid=%b pc=%h expected 1/100", out_valid, out_pc); end
    n_checks++; if (out_instr !== (32'h100 ^ KEY)) begin n_fail++; $display("FAIL redir_first_instr: got %h expected %h", out_instr, 32'h100 ^ KEY); end
    @(negedge clk); #1;
    n_checks++; if (out_pc !== 32'h104) begin n_fail++; $display("FAIL redir_second_pc: got %h expected 104", out_pc); end
  endtask

  // Redirect in the same cycle as a response and a would-be pop.
  task automatic test_redirect_collide();
    do_reset();
    imem_req_ready = 1'b1; out_ready = 1'b1;
    #1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h4) begin n_fail++; $display("FAIL coll_pre: got valid=%b pc=%h expected 1/4", out_valid, out_pc); end
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL coll_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL coll_req_valid: got %b expected 0", imem_req_valid); end
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    n_checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL coll_flush: got count=%0d valid=%b expected 0/0", count, out_valid); end
    n_checks++; if (imem_req_addr !== 32'h200) begin n_fail++; $display("FAIL coll_addr: got %h expected 200", imem_req_addr); end
    @(negedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL coll_gap: got %b expected 0", out_valid); end
    @(negedge clk); #1;
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h200) begin n_fail++; $display("FAIL coll_first_pc: got valid=%b pc=%h expected 1/200", out_valid, out_pc); end
    @(negedge clk); #1;
    n_checks++; if (out_pc !== 32'h204) begin n_fail++; $display("FAIL coll_second_pc: got %h expected 204", out_pc); end
  endtask

  // Reset while the queue holds three words and one is in flight.
  task automatic test_reset_midop();
    do_reset();
    imem_req_ready = 1'b1; out_ready = 1'b0;
    #1;
    repeat (4) @(negedge clk);
    #1;
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL midrst_pre_count: got %0d expected 3", count); end
    rst = 1'b1;
    #1;
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_req_valid: got %b expected 0", imem_req_valid); end
    @(negedge clk); #1;
    n_checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_state: got count=%0d valid=%b expected 0/0", count, out_valid); end
    n_checks++; if (out_pc !== 32'h0 || out_instr !== 32'h0) begin n_fail++; $display("FAIL midrst_head: got pc=%h instr=%h expected 0/0", out_pc, out_instr); end
    rst = 1'b0;
    #1;
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL midrst_first_req: got valid=%b addr=%h expected 1/0", imem_req_valid, imem_req_addr); end
    @(negedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_no_stale: got %b expected 0", out_valid); end
    @(negedge clk); #1;
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || count !== 3'd1) begin n_fail++; $display("FAIL midrst_first_out: got valid=%b pc=%h count=%0d expected 1/0/1", out_valid, out_pc, count); end
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; out_ready = 1'b0; rsp_hold = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_req_stall();
    test_redirect_inflight();
    test_redirect_collide();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
